// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX serializer among AXIS byte sources.
// A grant is held for a whole packet; each byte is launched with tx_start and retired on the tx_busy fall.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*DATA_BITS-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]           s_tvalid,
    input  logic [NUM_REQ-1:0]           s_tlast,
    output logic [NUM_REQ-1:0]           s_tready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         active
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, pick, idx;
    logic          found, fire, last_q;
    // Scan from farthest to nearest so the first valid index after rr_ptr ends up in pick.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (s_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        s_tready = (state == SEND && !tx_busy) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
        fire     = state == SEND && !tx_busy && s_tvalid[grant_id];
        active   = state != IDLE;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = found ? SEND : IDLE;
            SEND:      state_nx = fire ? WAIT_ACK : SEND;
            WAIT_ACK:  state_nx = tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: state_nx = tx_busy ? WAIT_DONE : (last_q ? IDLE : SEND);
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= IW'(NUM_REQ - 1);
            grant_id <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_start <= fire;
            if (state == IDLE && found) grant_id <= pick;
            if (fire) begin
                tx_data <= s_tdata[grant_id*DATA_BITS +: DATA_BITS];
                last_q  <= s_tlast[grant_id];
            end
            if (state == WAIT_DONE && !tx_busy && last_q) rr_ptr <= grant_id;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle table for single-byte handshakes, then packet sequences
// driven by queued sources and a serializer model, checked against an expected byte log.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*DB-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DB-1:0]   tx_data;
    logic            tx_start, tx_busy, active;
    logic [1:0]      grant_id;

    logic            src_en = 1'b0, ser_en = 1'b0, tb_busy = 1'b0;
    logic [N-1:0]    tv_valid = '0, tv_last = '0, pause = '0;
    logic [N*DB-1:0] tv_data = '0;
    logic [N-1:0]    src_valid, src_last;
    logic [N*DB-1:0] src_data;
    logic            ser_busy;
    int              ser_lat = 2, ser_frame = 5;

    assign s_tvalid = src_en ? src_valid : tv_valid;
    assign s_tlast  = src_en ? src_last  : tv_last;
    assign s_tdata  = src_en ? src_data  : tv_data;
    assign tx_busy  = ser_en ? ser_busy  : tb_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active)
    );

    // Per-requester byte queues: tail written by the stimulus, head advanced by the source.
    logic [8:0] mem [N][16];
    int head [N];
    int tail [N] = '{default: 0};
    int flush_gen = 0;

    initial begin
        int gen_seen;
        gen_seen = 0;
        for (int i = 0; i < N; i++) head[i] = 0;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_start && head[grant_id] < tail[grant_id]) head[grant_id]++;
            if (gen_seen != flush_gen) begin
                gen_seen = flush_gen;
                for (int i = 0; i < N; i++) head[i] = tail[i];
            end
            for (int i = 0; i < N; i++) begin
                src_valid[i]         = head[i] < tail[i] && !pause[i];
                src_data[i*DB +: DB] = head[i] < tail[i] ? mem[i][head[i]][7:0] : 8'h00;
                src_last[i]          = head[i] < tail[i] ? mem[i][head[i]][8] : 1'b0;
            end
        end
    end

    initial begin
        ser_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_en && tx_start) begin
                repeat (ser_lat) @(negedge clk);
                ser_busy = 1'b1;
                repeat (ser_frame) @(negedge clk);
                ser_busy = 1'b0;
            end
        end
    end

    logic [9:0] log_l [64];
    logic [9:0] exp_l [64];
    int         log_n = 0, exp_n = 0, chk_ptr = 0;
    logic [7:0] last_data = 8'h00;

    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            log_l[log_n] = {grant_id, tx_data};
            log_n++;
            last_data = tx_data;
        end
    end

    int bad_hot = 0, bad_busy = 0, bad_hold = 0;
    initial forever begin
        @(negedge clk);
        #1;
        if (!$onehot0(s_tready)) bad_hot++;
        if (tx_busy && s_tready != '0) bad_busy++;
        if (active && tx_busy && tx_data != last_data) bad_hold++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {s_tready, tx_start, tx_data, grant_id, active};
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic add_exp(input logic [1:0] g, input logic [7:0] d);
        exp_l[exp_n] = {g, d};
        exp_n++;
    endtask

    task automatic run_until(input int n);
        int c;
        c = 0;
        while ((log_n < n || active) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("run_budget", 32'(c < 3000), 32'd1);
    endtask

    task automatic wait_log(input int n);
        int c;
        c = 0;
        while (log_n < n && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("start_seen", 32'(log_n), 32'(n));
    endtask

    task automatic check_log();
        chk("log_count", 32'(log_n), 32'(exp_n));
        for (int k = chk_ptr; k < exp_n; k++) chk($sformatf("log[%0d]", k), 32'(log_l[k]), 32'(exp_l[k]));
        chk_ptr = exp_n;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  e_ready;
        logic        e_start;
        logic [7:0]  e_data;
        logic [1:0]  e_grant;
        logic        e_active;
    } vec_t;
    vec_t tbl [15];

    initial begin
        int c, oth, base;
        tbl[0]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{4'h1, 4'h1, 32'h0000_0055, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[2]  = '{4'h1, 4'h1, 32'h0000_0055, 1'b0, 4'h1, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[3]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b1, 8'h55, 2'd0, 1'b1};
        tbl[4]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b0, 8'h55, 2'd0, 1'b1};
        tbl[5]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b0, 8'h55, 2'd0, 1'b1};
        tbl[6]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 8'h55, 2'd0, 1'b1};
        tbl[7]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0};
        tbl[8]  = '{4'h2, 4'h2, 32'h0000_1100, 1'b1, 4'h0, 1'b0, 8'h55, 2'd0, 1'b0};
        tbl[9]  = '{4'h2, 4'h2, 32'h0000_1100, 1'b1, 4'h0, 1'b0, 8'h55, 2'd1, 1'b1};
        tbl[10] = '{4'h2, 4'h2, 32'h0000_1100, 1'b0, 4'h2, 1'b0, 8'h55, 2'd1, 1'b1};
        tbl[11] = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1, 1'b1};
        tbl[12] = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1, 1'b1};
        tbl[13] = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1, 1'b1};
        tbl[14] = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tv_valid = tbl[i].valid;
            tv_last  = tbl[i].last;
            tv_data  = tbl[i].data;
            tb_busy  = tbl[i].busy;
            #1;
            chk($sformatf("vec[%0d]", i), 32'(outs()),
                32'({tbl[i].e_ready, tbl[i].e_start, tbl[i].e_data, tbl[i].e_grant, tbl[i].e_active}));
        end
        add_exp(2'd0, 8'h55);
        add_exp(2'd1, 8'h11);
        check_log();

        // Round-robin after a fresh reset: r1, r3, then r1 again.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tv_valid = '0;
        tb_busy  = 1'b0;
        src_en   = 1'b1;
        ser_en   = 1'b1;
        push(1, 8'h11, 1'b1);
        push(3, 8'h33, 1'b1);
        push(1, 8'h12, 1'b1);
        add_exp(2'd1, 8'h11);
        add_exp(2'd3, 8'h33);
        add_exp(2'd1, 8'h12);
        run_until(exp_n);
        check_log();

        // Packet lock: r2's three bytes go out before r0's waiting byte.
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        push(0, 8'h0F, 1'b1);
        add_exp(2'd2, 8'hA1);
        add_exp(2'd2, 8'hA2);
        add_exp(2'd2, 8'hA3);
        add_exp(2'd0, 8'h0F);
        run_until(exp_n);
        check_log();

        // Grantee r1 stalls mid-packet while r3 waits.
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b1);
        push(3, 8'hD1, 1'b1);
        wait_log(exp_n + 1);
        pause[1] = 1'b1;
        base = log_n;
        oth  = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if ((s_tready & 4'b1101) != 4'b0000) oth++;
        end
        chk("stall_no_start", 32'(log_n), 32'(base));
        chk("stall_other_ready", 32'(oth), 32'd0);
        chk("stall_ready", 32'(s_tready), 32'h2);
        chk("stall_lock", 32'({grant_id, active}), 32'({2'd1, 1'b1}));
        pause[1] = 1'b0;
        add_exp(2'd1, 8'hB1);
        add_exp(2'd1, 8'hB2);
        add_exp(2'd3, 8'hD1);
        run_until(exp_n);
        check_log();

        // Serializer busy immediately for three cycles after each start.
        ser_lat   = 0;
        ser_frame = 3;
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE2, 1'b1);
        add_exp(2'd0, 8'hE1);
        add_exp(2'd0, 8'hE2);
        run_until(exp_n);
        check_log();

        // Asynchronous reset while waiting for the frame to finish.
        ser_lat   = 2;
        ser_frame = 5;
        push(3, 8'hF1, 1'b0);
        push(3, 8'hF2, 1'b1);
        add_exp(2'd3, 8'hF1);
        wait_log(exp_n);
        c = 0;
        while (!tx_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        chk("pre_reset_busy", 32'({tx_busy, active}), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'(outs()), 32'h0);
        ser_en = 1'b0;
        flush_gen++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        ser_en = 1'b1;
        push(0, 8'h61, 1'b1);
        push(2, 8'h62, 1'b1);
        add_exp(2'd0, 8'h61);
        add_exp(2'd2, 8'h62);
        run_until(exp_n);
        check_log();

        chk("tready_onehot", 32'(bad_hot), 32'd0);
        chk("tready_while_busy", 32'(bad_busy), 32'd0);
        chk("tx_data_hold", 32'(bad_hold), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
